// File: rtl/ram_arb_pkg.sv
// Shared defaults and client id encoding for the two-client RAM arbiter.
package ram_arb_pkg;

    localparam int RAM_ADDR_W    = 2;
    localparam int RAM_DATA_W    = 16;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        CLI0 = 1'b0,
        CLI1 = 1'b1
    } cli_id_t;

    function automatic cli_id_t other_cli(input cli_id_t id);
        return (id == CLI0) ? CLI1 : CLI0;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational round-robin pick with an optional bounded lock for the previous owner.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  logic    lock0,
    input  logic    lock1,
    input  cli_id_t last_gnt,
    input  logic    burst_ok,
    output logic    gnt0,
    output logic    gnt1,
    output cli_id_t sel
);

    logic both;
    logic keep;

    assign both = req0 && req1;
    // Contention only stays with the previous owner while it is locked and under its burst limit.
    assign keep = both && burst_ok && ((last_gnt == CLI1) ? lock1 : lock0);

    always_comb begin
        sel = CLI0;
        if (both) begin
            sel = keep ? last_gnt : other_cli(last_gnt);
        end else if (req1) begin
            sel = CLI1;
        end
    end

    assign gnt0 = (req0 || req1) && (sel == CLI0);
    assign gnt1 = (req0 || req1) && (sel == CLI1);

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-client arbiter in front of a single-port sync RAM: pick, RAM mux, read-return routing.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    cli_id_t                      last_gnt_q, last_gnt_d;
    logic                         held_q, held_d;
    logic [CNT_W-1:0]             burst_cnt_q, burst_cnt_d;
    logic [1:0]                   rd_pend_q, rd_pend_d;
    logic [1:0][DATA_W-1:0]       rhold_q, rhold_d;

    logic    pick_g0, pick_g1;
    cli_id_t sel;
    logic    burst_ok;
    logic    any_gnt;
    logic    same_owner, other_wait, sel_lock;

    assign burst_ok = held_q && (burst_cnt_q < CNT_MAX);

    ram_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .lock0    (lock0),
        .lock1    (lock1),
        .last_gnt (last_gnt_q),
        .burst_ok (burst_ok),
        .gnt0     (pick_g0),
        .gnt1     (pick_g1),
        .sel      (sel)
    );

    // Gating with rst keeps the RAM pins quiet for the whole reset window.
    assign gnt0    = pick_g0 && !rst;
    assign gnt1    = pick_g1 && !rst;
    assign any_gnt = gnt0 || gnt1;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (gnt1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end
    end

    assign same_owner = held_q && (last_gnt_q == sel);
    assign other_wait = (sel == CLI0) ? req1 : req0;
    assign sel_lock   = (sel == CLI0) ? lock0 : lock1;

    always_comb begin
        last_gnt_d  = last_gnt_q;
        held_d      = any_gnt;
        burst_cnt_d = '0;
        if (any_gnt) begin
            last_gnt_d = sel;
            if (same_owner && other_wait && sel_lock && (burst_cnt_q != CNT_MAX)) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_pend_d = {gnt1 && !we1, gnt0 && !we0};
        rhold_d   = rhold_q;
        for (int i = 0; i < 2; i++) begin
            if (rd_pend_q[i]) begin
                rhold_d[i] = ram_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= CLI1;
            held_q      <= 1'b0;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
            rhold_q     <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            held_q      <= held_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rhold_q     <= rhold_d;
        end
    end

    // Read data is live from the RAM during the valid cycle, then held until the next read.
    assign rvalid0 = rd_pend_q[0] && !rst;
    assign rvalid1 = rd_pend_q[1] && !rst;
    assign rdata0  = rst ? '0 : (rd_pend_q[0] ? ram_dout : rhold_q[0]);
    assign rdata1  = rst ? '0 : (rd_pend_q[1] ? ram_dout : rhold_q[1]);

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural single-port sync RAM.
module tb_ram_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        ram_we;
    logic [1:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] mem [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_arbiter_2p #(.ADDR_W(2), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic rst_pulse();
        rst = 1;
        nxt();
        rst = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".gnt"},  {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, ".rv"},   {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, ".rd0"},  rdata0, 32'd0);
        chk({tag, ".rd1"},  rdata1, 32'd0);
        chk({tag, ".ram"},  {ram_we, ram_addr, ram_din}, 32'd0);
    endtask

    initial begin
        logic [9:0] exp3;
        idle();
        rst = 1;
        // Requests during reset must not reach the RAM.
        req0 = 1; we0 = 1; addr0 = 2'd1; wdata0 = 16'h1234;
        nxt(); nxt();
        @(negedge clk);
        chk_quiet("rst");
        @(posedge clk); #1;
        rst = 0;

        // 1: write then read by client 0
        req0 = 1; we0 = 1; addr0 = 2'd2; wdata0 = 16'h0009;
        @(negedge clk);
        chk("t1.wr.gnt0", gnt0, 1);
        chk("t1.wr.gnt1", gnt1, 0);
        chk("t1.wr.ram",  {ram_we, ram_addr, ram_din}, {1'b1, 2'd2, 16'h0009});
        nxt();
        we0 = 0;
        @(negedge clk);
        chk("t1.rd.gnt0", gnt0, 1);
        chk("t1.rd.we",   ram_we, 0);
        chk("t1.rd.rv0early", rvalid0, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t1.rv0",   rvalid0, 1);
        chk("t1.rd0",   rdata0, 16'h0009);
        chk("t1.rv1",   rvalid1, 0);
        nxt();
        @(negedge clk);
        chk("t1.rv0off", rvalid0, 0);
        chk("t1.rd0hold", rdata0, 16'h0009);

        // Preload addr 0/1 for the alternation test.
        req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 16'h00A0;
        nxt();
        idle();
        req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 16'h00B1;
        nxt();
        idle();
        rst_pulse();

        // 2: both read, no lock -> 0,1,0,1
        req0 = 1; addr0 = 2'd0; req1 = 1; addr1 = 2'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2.g0[%0d]", k), gnt0, (k % 2 == 0));
            chk($sformatf("t2.g1[%0d]", k), gnt1, (k % 2 == 1));
            if (k > 0) begin
                chk($sformatf("t2.rv0[%0d]", k), rvalid0, (k % 2 == 1));
                chk($sformatf("t2.rv1[%0d]", k), rvalid1, (k % 2 == 0));
                if (k % 2 == 1) chk($sformatf("t2.rd0[%0d]", k), rdata0, 16'h00A0);
                else            chk($sformatf("t2.rd1[%0d]", k), rdata1, 16'h00B1);
            end
            nxt();
        end
        idle();
        @(negedge clk);
        chk("t2.rv1last", rvalid1, 1);
        chk("t2.rd1last", rdata1, 16'h00B1);
        chk("t2.rv0last", rvalid0, 0);
        nxt();
        rst_pulse();

        // 3: lock0 burst of 4 against a waiting client 1
        exp3 = 10'b0111101111;
        req0 = 1; lock0 = 1; addr0 = 2'd0; req1 = 1; addr1 = 2'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t3.g0[%0d]", k), gnt0, exp3[k]);
            chk($sformatf("t3.g1[%0d]", k), gnt1, !exp3[k]);
            nxt();
        end
        req1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t3.solo[%0d]", k), {gnt1, gnt0}, 2'b01);
            nxt();
        end
        idle();
        rst_pulse();

        // 4: write by 0 then read of same address by 1 on the next cycle
        req0 = 1; we0 = 1; addr0 = 2'd3; wdata0 = 16'h000D;
        @(negedge clk);
        chk("t4.wr", {gnt1, gnt0, ram_we}, 3'b011);
        nxt();
        idle();
        req1 = 1; addr1 = 2'd3;
        @(negedge clk);
        chk("t4.g1", gnt1, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("t4.rv1", rvalid1, 1);
        chk("t4.rd1", rdata1, 16'h000D);

        // 5: reset right after a granted read by client 1
        req1 = 1; addr1 = 2'd1;
        @(negedge clk);
        chk("t5.g1", gnt1, 1);
        nxt();
        rst = 1;
        req0 = 1; we0 = 1; addr0 = 2'd3; wdata0 = 16'h0055;
        req1 = 1; we1 = 0;
        @(negedge clk);
        chk_quiet("t5.r0");
        nxt();
        @(negedge clk);
        chk_quiet("t5.r1");
        @(posedge clk); #1;
        rst = 0; we0 = 0;
        @(negedge clk);
        chk("t5.first", {gnt1, gnt0}, 2'b01);
        nxt();
        @(negedge clk);
        chk("t5.second", {gnt1, gnt0}, 2'b10);
        nxt();
        idle();
        rst_pulse();

        // 6: client 1 request appears and vanishes inside client 0's locked burst
        req0 = 1; lock0 = 1; addr0 = 2'd0;
        for (int k = 0; k < 6; k++) begin
            req1  = (k == 1 || k == 2);
            addr1 = 2'd3;
            @(negedge clk);
            chk($sformatf("t6.g[%0d]", k), {gnt1, gnt0}, 2'b01);
            chk($sformatf("t6.addr[%0d]", k), ram_addr, 2'd0);
            chk($sformatf("t6.rv1[%0d]", k), rvalid1, 0);
            nxt();
        end
        idle();
        @(negedge clk);
        chk("t6.rv1end", rvalid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
